csr_exec_unit: RTL

//  Executes CSR instructions (CSRRW/S/C and immediate forms) and the trap flow (ECALL entry, MRET return)

---
 rtl/csr_exec_unit_pkg.sv | 36 +++
 rtl/csr_exec_unit_alu.sv | 22 ++
 rtl/csr_exec_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/csr_exec_unit_pkg.sv
// Shared definitions for the CSR execution unit: op encoding, machine-mode CSR addresses
// and mstatus field positions.
package csr_exec_unit_pkg;

    typedef enum logic [2:0] {
        CSR_RW    = 3'd0,
        CSR_RS    = 3'd1,
        CSR_RC    = 3'd2,
        CSR_RWI   = 3'd3,
        CSR_RSI   = 3'd4,
        CSR_RCI   = 3'd5,
        CSR_ECALL = 3'd6,
        CSR_MRET  = 3'd7
    } csr_op_t;

    localparam logic [11:0] CSR_SATP     = 12'h180;
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MSTATUS_MPP_LO = 11;

    // Set/clear forms skip the write entirely when the source operand is zero.
    function automatic logic is_set_clear(input csr_op_t op);
        return (op == CSR_RS) || (op == CSR_RC) || (op == CSR_RSI) || (op == CSR_RCI);
    endfunction

endpackage

// File: rtl/csr_exec_unit_alu.sv
// New CSR value for read-modify-write ops: write, set bits, or clear bits.
module csr_alu
    import csr_exec_unit_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  csr_op_t         op,
    input  logic [XLEN-1:0] old_val,
    input  logic [XLEN-1:0] src,
    output logic [XLEN-1:0] new_val
);

    always_comb begin
        new_val = src;
        case (op)
            CSR_RS, CSR_RSI: new_val = old_val | src;
            CSR_RC, CSR_RCI: new_val = old_val & ~src;
            default:         new_val = src;
        endcase
    end

endmodule

// File: rtl/csr_exec_unit.sv
// CSR instruction and trap-flow sequencer in front of the machine-mode CSR register file.
//
// state     | meaning
// S_IDLE    | ready for a request
// S_RD      | rw_CSR selects target, old value sampled
// S_WR      | csr_we pulse with read-modify-write result
// S_T_EPC   | ECALL: csr_we pulse writing mepc
// S_T_CAUSE | ECALL: csr_we pulse writing mcause
// S_T_STRD  | ECALL: reading mstatus
// S_T_STWR  | ECALL: csr_we pulse writing trap-entry mstatus
// S_T_VEC   | ECALL: reading mtvec for redirect target
// S_M_STRD  | MRET: reading mstatus
// S_M_STWR  | MRET: csr_we pulse writing return mstatus
// S_M_EPC   | MRET: reading mepc for redirect target
// S_RESP    | out_valid held until out_ready
module csr_exec_unit
    import csr_exec_unit_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int ECALL_CAUSE = 11
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  csr_op_t         in_op,
    input  logic [11:0]     in_addr,
    input  logic [XLEN-1:0] in_src,
    input  logic            in_src_zero,
    input  logic [XLEN-1:0] in_pc,
    output logic [11:0]     rw_CSR,
    input  logic [XLEN-1:0] readData_CSR,
    output logic            csr_we,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rdata,
    output logic            out_redirect,
    output logic [XLEN-1:0] out_pc
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD, S_WR,
        S_T_EPC, S_T_CAUSE, S_T_STRD, S_T_STWR, S_T_VEC,
        S_M_STRD, S_M_STWR, S_M_EPC,
        S_RESP
    } csr_exec_state_t;

    localparam logic [XLEN-1:0] VEC_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    csr_exec_state_t state;
    csr_op_t         op_q;
    logic [11:0]     addr_q;
    logic [XLEN-1:0] src_q;
    logic            src_zero_q;
    logic [XLEN-1:0] alu_new;
    logic [XLEN-1:0] ecall_mstatus;
    logic [XLEN-1:0] mret_mstatus;

    assign in_ready = (state == S_IDLE);

    csr_alu #(.XLEN(XLEN)) u_alu (
        .op      (op_q),
        .old_val (readData_CSR),
        .src     (src_q),
        .new_val (alu_new)
    );

    // Trap entry stacks MIE into MPIE and records M-mode as previous privilege;
    // return does the reverse and drops MPP to U.
    always_comb begin
        ecall_mstatus = readData_CSR;
        ecall_mstatus[MSTATUS_MPIE] = readData_CSR[MSTATUS_MIE];
        ecall_mstatus[MSTATUS_MIE] = 1'b0;
        ecall_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

        mret_mstatus = readData_CSR;
        mret_mstatus[MSTATUS_MIE] = readData_CSR[MSTATUS_MPIE];
        mret_mstatus[MSTATUS_MPIE] = 1'b1;
        mret_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            op_q         <= CSR_RW;
            addr_q       <= '0;
            src_q        <= '0;
            src_zero_q   <= 1'b0;
            rw_CSR       <= '0;
            csr_we       <= 1'b0;
            csr_waddr    <= '0;
            csr_wdata    <= '0;
            out_valid    <= 1'b0;
            out_rdata    <= '0;
            out_redirect <= 1'b0;
            out_pc       <= '0;
        end else begin
            csr_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q       <= in_op;
                        addr_q     <= in_addr;
                        src_q      <= in_src;
                        src_zero_q <= in_src_zero;
                        case (in_op)
                            CSR_ECALL: begin
                                csr_we    <= 1'b1;
                                csr_waddr <= CSR_MEPC;
                                csr_wdata <= in_pc;
                                state     <= S_T_EPC;
                            end
                            CSR_MRET: begin
                                rw_CSR <= CSR_MSTATUS;
                                state  <= S_M_STRD;
                            end
                            default: begin
                                rw_CSR <= in_addr;
                                state  <= S_RD;
                            end
                        endcase
                    end
                end
                S_RD: begin
                    out_rdata <= readData_CSR;
                    if (is_set_clear(op_q) && src_zero_q) begin
                        out_valid    <= 1'b1;
                        out_redirect <= 1'b0;
                        out_pc       <= '0;
                        state        <= S_RESP;
                    end else begin
                        csr_we    <= 1'b1;
                        csr_waddr <= addr_q;
                        csr_wdata <= alu_new;
                        state     <= S_WR;
                    end
                end
                S_WR: begin
                    out_valid    <= 1'b1;
                    out_redirect <= 1'b0;
                    out_pc       <= '0;
                    state        <= S_RESP;
                end
                S_T_EPC: begin
                    csr_we    <= 1'b1;
                    csr_waddr <= CSR_MCAUSE;
                    csr_wdata <= XLEN'(ECALL_CAUSE);
                    state     <= S_T_CAUSE;
                end
                S_T_CAUSE: begin
                    rw_CSR <= CSR_MSTATUS;
                    state  <= S_T_STRD;
                end
                S_T_STRD: begin
                    csr_we    <= 1'b1;
                    csr_waddr <= CSR_MSTATUS;
                    csr_wdata <= ecall_mstatus;
                    state     <= S_T_STWR;
                end
                S_T_STWR: begin
                    rw_CSR <= CSR_MTVEC;
                    state  <= S_T_VEC;
                end
                S_T_VEC: begin
                    out_valid    <= 1'b1;
                    out_rdata    <= '0;
                    out_redirect <= 1'b1;
                    out_pc       <= readData_CSR & VEC_MASK;
                    state        <= S_RESP;
                end
                S_M_STRD: begin
                    csr_we    <= 1'b1;
                    csr_waddr <= CSR_MSTATUS;
                    csr_wdata <= mret_mstatus;
                    state     <= S_M_STWR;
                end
                S_M_STWR: begin
                    rw_CSR <= CSR_MEPC;
                    state  <= S_M_EPC;
                end
                S_M_EPC: begin
                    out_valid    <= 1'b1;
                    out_rdata    <= '0;
                    out_redirect <= 1'b1;
                    out_pc       <= readData_CSR;
                    state        <= S_RESP;
                end
                S_RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
